pattern_tx: RTL and testbench

//  Serial bit-stream transmitter: the source end of the 1-bit serial line consumed by the sequence detector.

---
 rtl/pattern_tx_pkg.sv | 16 +
 rtl/pattern_tx_if.sv | 11 +
 rtl/pattern_tx_shreg.sv | 34 +++
 rtl/pattern_tx.sv | 128 ++++++++++++
 tb/tb_pattern_tx.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/pattern_tx_pkg.sv
// Shared definitions for the pattern_tx serial transmitter: FSM state type and its 2-bit encodings.
package pattern_tx_pkg;

   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_SHIFT = 2'b01;
   localparam logic [1:0] ST_PAR   = 2'b10;
   localparam logic [1:0] ST_GAP   = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      SHIFT = ST_SHIFT,
      PAR   = ST_PAR,
      GAP   = ST_GAP
   } state_t;

endpackage

// File: rtl/pattern_tx_if.sv
// Word-load handshake between a pattern source (master) and pattern_tx (slave).
interface pattern_tx_if #(
   parameter int WIDTH = 8
);
   logic             load_valid;
   logic             load_ready;
   logic [WIDTH-1:0] load_data;

   modport master (output load_valid, output load_data, input load_ready);
   modport slave  (input load_valid, input load_data, output load_ready);
endinterface

// File: rtl/pattern_tx_shreg.sv
// Load/shift register for pattern_tx. Holds the bits still to be sent after the one currently on x;
// next_bit is the bit the top should put on x at the coming edge (head of din while loading).
module pattern_tx_shreg #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] din,
   output logic             next_bit
);

   logic [WIDTH-1:0] q;

   function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
      return MSB_FIRST ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
   endfunction

   function automatic logic head(input logic [WIDTH-1:0] v);
      return MSB_FIRST ? v[WIDTH-1] : v[0];
   endfunction

   // The first bit leaves straight from din, so only the remainder is stored on load.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)     q <= '0;
      else if (load)  q <= advance(din);
      else if (shift) q <= advance(q);
   end

   assign next_bit = load ? head(din) : head(q);

endmodule

// File: rtl/pattern_tx.sv
// Serial pattern transmitter: accepts a word over a valid/ready handshake and shifts it out on x.
// Optional even-parity bit after the data is enabled by defining PATTERN_TX_PARITY_EN.
module pattern_tx
   import pattern_tx_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter bit MSB_FIRST  = 1'b1,
   parameter int GAP_CYCLES = 2
) (
   input  logic         clk,
   input  logic         reset,
   pattern_tx_if.slave  load,
   output logic         x,
   output logic         busy,
   output logic         done
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam int GW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [CW-1:0] COUNT_LOAD = CW'(WIDTH - 1);
   localparam logic [GW-1:0] GAP_LOAD   = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

   state_t        state, state_nx;
   logic [CW-1:0] count, count_nx;
   logic [GW-1:0] gap_cnt, gap_nx;
   logic          x_nx;
   logic          load_en, shift_en;
   logic          next_bit;
   logic          accept;

   assign load.load_ready = (state == IDLE) && reset;
   assign accept          = load.load_valid && load.load_ready;
   assign busy            = (state != IDLE);

   pattern_tx_shreg #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_shreg (
      .clk      (clk),
      .reset    (reset),
      .load     (load_en),
      .shift    (shift_en),
      .din      (load.load_data),
      .next_bit (next_bit)
   );

`ifdef PATTERN_TX_PARITY_EN
   logic par_bit;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)      par_bit <= 1'b0;
      else if (accept) par_bit <= ^load.load_data;
   end
`endif

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         count   <= '0;
         gap_cnt <= '0;
         x       <= 1'b0;
      end else begin
         state   <= state_nx;
         count   <= count_nx;
         gap_cnt <= gap_nx;
         x       <= x_nx;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nx = state;
      count_nx = count;
      gap_nx   = gap_cnt;
      x_nx     = 1'b0;
      load_en  = 1'b0;
      shift_en = 1'b0;
      done     = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               load_en  = 1'b1;
               x_nx     = next_bit;
               count_nx = COUNT_LOAD;
               state_nx = SHIFT;
            end
         end
         SHIFT: begin
            if (count != '0) begin
               shift_en = 1'b1;
               x_nx     = next_bit;
               count_nx = count - CW'(1);
            end else begin
`ifdef PATTERN_TX_PARITY_EN
               x_nx     = par_bit;
               state_nx = PAR;
`else
               done = 1'b1;
               if (GAP_CYCLES > 0) begin
                  state_nx = GAP;
                  gap_nx   = GAP_LOAD;
               end else begin
                  state_nx = IDLE;
               end
`endif
            end
         end
`ifdef PATTERN_TX_PARITY_EN
         PAR: begin
            done = 1'b1;
            if (GAP_CYCLES > 0) begin
               state_nx = GAP;
               gap_nx   = GAP_LOAD;
            end else begin
               state_nx = IDLE;
            end
         end
`endif
         GAP: begin
            if (gap_cnt == '0) state_nx = IDLE;
            else               gap_nx   = gap_cnt - GW'(1);
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_pattern_tx.sv
// Self-checking bench for pattern_tx: three instances (MSB-first gap 2, LSB-first gap 2, MSB-first gap 0).
module tb_pattern_tx;

`ifdef PATTERN_TX_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif
   localparam int FRAME = 8 + PB;

   typedef struct {
      int         sel;
      logic [7:0] data;
      logic [7:0] seq;   // expected x order, seq[7] first
      logic       par;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   logic lv;
   logic [7:0] ld;
   int sel;

   logic x_a, busy_a, done_a;
   logic x_b, busy_b, done_b;
   logic x_c, busy_c, done_c;
   logic xo, busyo, doneo, readyo;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   pattern_tx_if #(.WIDTH(8)) bus_a ();
   pattern_tx_if #(.WIDTH(8)) bus_b ();
   pattern_tx_if #(.WIDTH(8)) bus_c ();

   assign bus_a.load_valid = lv && (sel == 0);
   assign bus_b.load_valid = lv && (sel == 1);
   assign bus_c.load_valid = lv && (sel == 2);
   assign bus_a.load_data  = ld;
   assign bus_b.load_data  = ld;
   assign bus_c.load_data  = ld;

   pattern_tx #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP_CYCLES(2)) dut_a (
      .clk(clk), .reset(reset), .load(bus_a.slave), .x(x_a), .busy(busy_a), .done(done_a));
   pattern_tx #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP_CYCLES(2)) dut_b (
      .clk(clk), .reset(reset), .load(bus_b.slave), .x(x_b), .busy(busy_b), .done(done_b));
   pattern_tx #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP_CYCLES(0)) dut_c (
      .clk(clk), .reset(reset), .load(bus_c.slave), .x(x_c), .busy(busy_c), .done(done_c));

   always_comb begin
      xo = x_a; busyo = busy_a; doneo = done_a; readyo = bus_a.load_ready;
      case (sel)
         1: begin xo = x_b; busyo = busy_b; doneo = done_b; readyo = bus_b.load_ready; end
         2: begin xo = x_c; busyo = busy_c; doneo = done_c; readyo = bus_c.load_ready; end
         default: ;
      endcase
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // One word, then gap, then back to IDLE; load_data is scrambled after the accepting edge.
   task automatic run_frame(input logic [7:0] data, input logic [7:0] seq, input logic par);
      @(negedge clk);
      check("ready_before_load", readyo, 1);
      lv = 1'b1;
      ld = data;
      @(negedge clk);
      lv = 1'b0;
      ld = ~data;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("bit%0d_of_%02h", i, data), xo, seq[7-i]);
         check($sformatf("done_bit%0d_of_%02h", i, data), doneo, (i == 7) && (PB == 0));
         check("ready_low_in_frame", readyo, 0);
         @(negedge clk);
      end
`ifdef PATTERN_TX_PARITY_EN
      check($sformatf("parity_of_%02h", data), xo, par);
      check("done_on_parity", doneo, 1);
      @(negedge clk);
`else
      par = par;
`endif
      for (int g = 0; g < 2; g++) begin
         check("gap_x", xo, 0);
         check("gap_busy", busyo, 1);
         check("gap_ready", readyo, 0);
         check("gap_done", doneo, 0);
         @(negedge clk);
      end
      check("idle_busy", busyo, 0);
      check("idle_ready", readyo, 1);
      check("idle_x", xo, 0);
   endtask

   // load_valid held high across two words; records x and done streams from the first bit on.
   task automatic run_stream(input string nm, input logic [7:0] w0, input logic [7:0] w1,
                             input int gap, input logic [31:0] exp_x, input logic [31:0] exp_d);
      logic [31:0] xs = '0;
      logic [31:0] ds = '0;
      int len = 2 * FRAME + gap + 1;
      @(negedge clk);
      lv = 1'b1;
      ld = w0;
      @(negedge clk);
      ld = w1;
      for (int j = 0; j < len; j++) begin
         xs = {xs[30:0], xo};
         ds = {ds[30:0], doneo};
         if (j == FRAME + gap + 1) lv = 1'b0;
         @(negedge clk);
      end
      lv = 1'b0;
      check({nm, "_x_stream"}, xs, exp_x);
      check({nm, "_done_stream"}, ds, exp_d);
      repeat (FRAME + gap + 2) @(negedge clk);
      check({nm, "_drained_busy"}, busyo, 0);
      check({nm, "_drained_ready"}, readyo, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t vecs[7];
      int   ones;
      vecs[0] = '{sel: 0, data: 8'b1001_1101, seq: 8'b1001_1101, par: 1'b1};
      vecs[1] = '{sel: 0, data: 8'hA5,        seq: 8'b1010_0101, par: 1'b0};
      vecs[2] = '{sel: 0, data: 8'h3C,        seq: 8'b0011_1100, par: 1'b0};
      vecs[3] = '{sel: 1, data: 8'b0000_0001, seq: 8'b1000_0000, par: 1'b1};
      vecs[4] = '{sel: 1, data: 8'b1100_1010, seq: 8'b0101_0011, par: 1'b0};
      vecs[5] = '{sel: 0, data: 8'b0000_0111, seq: 8'b0000_0111, par: 1'b1};
      vecs[6] = '{sel: 1, data: 8'hFF,        seq: 8'b1111_1111, par: 1'b0};

      // Reset held with load_valid high
      sel   = 0;
      reset = 1'b0;
      lv    = 1'b1;
      ld    = 8'h5A;
      repeat (2) @(negedge clk);
      check("rst_x", xo, 0);
      check("rst_busy", busyo, 0);
      check("rst_done", doneo, 0);
      check("rst_ready", readyo, 0);
      reset = 1'b1;
      lv    = 1'b0;
      #1;
      check("post_rst_ready", readyo, 1);
      check("post_rst_busy", busyo, 0);

      foreach (vecs[i]) begin
         sel = vecs[i].sel;
         run_frame(vecs[i].data, vecs[i].seq, vecs[i].par);
      end

      sel = 0;
`ifdef PATTERN_TX_PARITY_EN
      run_stream("holdoff_gap2", 8'hA5, 8'h3C, 2, 32'(21'b101001010000001111000), 32'(21'b000000001000000000001));
`else
      run_stream("holdoff_gap2", 8'hA5, 8'h3C, 2, 32'(19'b1010010100000111100), 32'(19'b0000000100000000001));
`endif

      sel = 2;
`ifdef PATTERN_TX_PARITY_EN
      run_stream("b2b_gap0", 8'hFF, 8'h81, 0, 32'(19'b1111111100100000010), 32'(19'b0000000010000000001));
`else
      run_stream("b2b_gap0", 8'hFF, 8'h81, 0, 32'(17'b11111111010000001), 32'(17'b00000001000000001));
`endif

      // Reset asserted while the 4th bit of 8'hFF is on x
      sel = 0;
      @(negedge clk);
      lv = 1'b1;
      ld = 8'hFF;
      @(negedge clk);
      lv = 1'b0;
      repeat (3) @(negedge clk);
      check("abort_bit3_before", xo, 1);
      #2 reset = 1'b0;
      #1;
      check("abort_x", xo, 0);
      check("abort_busy", busyo, 0);
      check("abort_done", doneo, 0);
      check("abort_ready", readyo, 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      ones  = 0;
      repeat (12) begin
         @(negedge clk);
         ones += int'(xo) + int'(busyo) + int'(doneo);
      end
      check("abort_no_residual", ones, 0);
      check("abort_ready_after", readyo, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
